// File: rtl/fns_decoder_seq.sv
// Sequential Fibonacci-numeral-system (FNS) to binary decoder.
// Takes one N-bit codeword per handshake, walks it LSB-first one bit per cycle,
// generates the Fibonacci weights on the fly and accumulates the weights of set bits.
// Reports adjacency violations / upstream errors on out_err and W-bit wrap on out_ovf.
module fns_decoder_seq #(
    parameter int N         = 8,    // codeword width (N >= 2)
    parameter int W         = 6,    // result width, 2^W >= w(N)
    parameter bit CHECK_ADJ = 1'b1  // 1 = adjacent set bits raise out_err
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_code,
    input  logic         in_err,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_err,
    output logic         out_ovf
);

    localparam int KW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [N-1:0] code_sr;   // codeword, shifted right so bit k sits at [0]
    logic [W:0]   prev_w;    // w(k-1)
    logic [W:0]   cur_w;     // w(k), one bit wider so w(N) fits when generated
    logic [W-1:0] acc;
    logic         err;
    logic         ovf;
    logic [KW-1:0] k;
    logic         last_bit;  // bit k-1 of the codeword, for the adjacency check

    logic         accept;
    logic         bit_k;
    logic         last_k;
    logic [W:0]   sum;

    assign accept = in_valid && in_ready;
    assign bit_k  = code_sr[0];
    assign last_k = (k == KW'(N - 1));
    // cur_w is below 2^W while bits are still being processed, so bit W of the sum is the carry out.
    assign sum    = {1'b0, acc} + cur_w;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    // NOTE: the default assignment at the top keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = in_err ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_k) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are pure decodes of the state register.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    assign out_data = acc;
    assign out_err  = err;
    assign out_ovf  = ovf;

    // Datapath: load on accept, then one bit per RUN cycle; everything holds in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_sr  <= '0;
            prev_w   <= '0;
            cur_w    <= '0;
            acc      <= '0;
            err      <= 1'b0;
            ovf      <= 1'b0;
            k        <= '0;
            last_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        code_sr  <= in_code;
                        prev_w   <= (W + 1)'(1);
                        cur_w    <= (W + 1)'(1);
                        acc      <= '0;
                        err      <= in_err;
                        ovf      <= 1'b0;
                        k        <= '0;
                        last_bit <= 1'b0;
                    end
                end
                RUN: begin
                    if (bit_k) begin
                        acc <= sum[W-1:0];
                        if (sum[W]) begin
                            ovf <= 1'b1;
                        end
                    end
                    if (CHECK_ADJ && bit_k && last_bit) begin
                        err <= 1'b1;
                    end
                    prev_w   <= cur_w;
                    cur_w    <= cur_w + prev_w;
                    code_sr  <= code_sr >> 1;
                    k        <= k + KW'(1);
                    last_bit <= bit_k;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fns_decoder_seq.sv
// Self-checking bench for fns_decoder_seq (N=8, W=6).
// Two instances share all inputs: one with the adjacency check, one without.
// Expected results come from a plain-arithmetic Fibonacci-sum model.
module tb_fns_decoder_seq;

    localparam int N = 8;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [N-1:0] in_code;
    logic         in_err;
    logic         out_ready;

    logic         in_ready_a, out_valid_a, out_err_a, out_ovf_a;
    logic [W-1:0] out_data_a;
    logic         in_ready_b, out_valid_b, out_err_b, out_ovf_b;
    logic [W-1:0] out_data_b;

    int n_checks = 0;
    int n_errors = 0;

    fns_decoder_seq #(.N(N), .W(W), .CHECK_ADJ(1'b1)) dut_adj (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_code(in_code), .in_err(in_err),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_err(out_err_a), .out_ovf(out_ovf_a)
    );

    fns_decoder_seq #(.N(N), .W(W), .CHECK_ADJ(1'b0)) dut_noadj (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_code(in_code), .in_err(in_err),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_err(out_err_b), .out_ovf(out_ovf_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Sum of Fibonacci weights 1,2,3,5,8,... of the set bits.
    function automatic int fns_sum(input logic [N-1:0] code);
        int wa = 1;
        int wb = 2;
        int s  = 0;
        int t;
        for (int i = 0; i < N; i++) begin
            if (code[i]) s += wa;
            t  = wa + wb;
            wa = wb;
            wb = t;
        end
        return s;
    endfunction

    task automatic check_outputs(input string tag, input logic [N-1:0] code, input logic ie);
        int   s;
        logic adj;
        s   = ie ? 0 : fns_sum(code);
        adj = ((code & (code >> 1)) != '0);
        check({tag, "_valid_a"}, out_valid_a, 1);
        check({tag, "_valid_b"}, out_valid_b, 1);
        check({tag, "_data_a"},  out_data_a, s % (1 << W));
        check({tag, "_data_b"},  out_data_b, s % (1 << W));
        check({tag, "_ovf_a"},   out_ovf_a, (s >= (1 << W)) ? 1 : 0);
        check({tag, "_ovf_b"},   out_ovf_b, (s >= (1 << W)) ? 1 : 0);
        check({tag, "_err_a"},   out_err_a, (ie || (!ie && adj)) ? 1 : 0);
        check({tag, "_err_b"},   out_err_b, ie ? 1 : 0);
        check({tag, "_rdy_a"},   in_ready_a, 0);
    endtask

    // Offer one word, measure latency, hold DONE for 'hold' cycles, then complete the handshake.
    task automatic run_word(input string tag, input logic [N-1:0] code, input logic ie, input int hold);
        int lat;
        @(negedge clk);
        check({tag, "_idle_rdy_a"}, in_ready_a, 1);
        check({tag, "_idle_rdy_b"}, in_ready_b, 1);
        in_code  = code;
        in_err   = ie;
        in_valid = 1'b1;
        @(posedge clk);          // accepting edge
        #1;
        in_valid = 1'b0;
        in_code  = N'($urandom);
        in_err   = 1'($urandom);
        lat = 0;
        while (!out_valid_a && lat < 40) begin
            check({tag, "_run_rdy"}, in_ready_a, 0);
            @(posedge clk);
            #1;
            lat++;
            in_valid = 1'($urandom);   // must be ignored outside IDLE
            in_code  = N'($urandom);
        end
        in_valid = 1'b0;
        // Edges after the accepting edge until out_valid is seen: N normally, none extra on in_err.
        check({tag, "_latency"}, lat, ie ? 0 : N);
        check_outputs(tag, code, ie);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom);
            check_outputs({tag, "_hold"}, code, ie);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drop_valid_a"}, out_valid_a, 0);
        check({tag, "_drop_valid_b"}, out_valid_b, 0);
        check({tag, "_back_rdy"}, in_ready_a, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] rc;
        logic         re;
        int           seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        in_err    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy",   in_ready_a, 1);
        check("rst_valid", out_valid_a, 0);
        check("rst_data",  out_data_a, 0);
        check("rst_err",   out_err_a, 0);
        check("rst_ovf",   out_ovf_a, 0);
        rst = 1'b0;

        // Directed cases.
        run_word("alt",     8'b1010_1010, 1'b0, 0);   // 54, no error
        run_word("one",     8'h01, 1'b0, 0);
        run_word("zero",    8'h00, 1'b0, 0);
        run_word("msb",     8'h80, 1'b0, 0);          // 34
        run_word("adj",     8'b0000_0011, 1'b0, 0);   // 3; err only with the check
        run_word("inerr",   8'hFF, 1'b1, 0);          // 0, err, one-cycle latency
        run_word("ff",      8'hFF, 1'b0, 0);          // 87 -> 23 with ovf
        run_word("hold5",   8'b0101_0010, 1'b0, 5);
        run_word("after",   8'h21, 1'b0, 0);

        // Reset in the middle of RUN (k=4): word is dropped.
        @(negedge clk);
        in_code  = 8'h55;
        in_err   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_rdy",   in_ready_a, 1);
        check("mid_rst_valid", out_valid_a, 0);
        check("mid_rst_data",  out_data_a, 0);
        check("mid_rst_err",   out_err_a, 0);
        check("mid_rst_ovf",   out_ovf_a, 0);
        seen = 0;
        repeat (N + 4) begin
            @(posedge clk);
            #1;
            if (out_valid_a || out_valid_b) seen++;
        end
        check("mid_rst_no_output", seen, 0);

        // Randomized words.
        for (int i = 0; i < 40; i++) begin
            rc = N'($urandom);
            re = ($urandom_range(0, 7) == 0);
            run_word("rnd", rc, re, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
